// File: rtl/clkgen_pkg.sv
// Shared types and default sizing for the multi-phase clock generator.
package clkgen_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 8;

  // Per-channel run state. The encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ARM  = 2'd1,
    CH_RUN  = 2'd2,
    CH_STOP = 2'd3
  } ch_state_e;

  // Width of a channel index. It never drops below one bit, so a
  // single-channel build still has a legal cfg_ch port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One clock channel. It holds a shadow and an active (half-period, phase)
// pair, a cycle counter and the IDLE/ARM/RUN/STOP sequencer. New settings
// reach the active pair only while idle or on a rising clk_out boundary, so a
// period already in progress is never cut short.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_half,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             clk_out,
  output logic             running,
  output ch_state_e        state_o
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic [DIV_W-1:0] sh_half_q, sh_half_d;
  logic [DIV_W-1:0] sh_phase_q, sh_phase_d;
  logic [DIV_W-1:0] act_half_q, act_half_d;
  logic [DIV_W-1:0] act_phase_q, act_phase_d;

  logic [DIV_W-1:0] h_eff;
  logic             at_last;

  // A half-period of zero behaves as one; at_last marks the toggle cycle.
  always_comb begin
    h_eff   = (act_half_q == '0) ? DIV_W'(1) : act_half_q;
    at_last = (cnt_q == (h_eff - DIV_W'(1)));
  end

  // Next-state, counter, output and config-transfer logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    sh_half_d   = sh_half_q;
    sh_phase_d  = sh_phase_q;
    act_half_d  = act_half_q;
    act_phase_d = act_phase_q;

    if (wr_en) begin
      sh_half_d  = wr_half;
      sh_phase_d = wr_phase;
    end

    case (state_q)
      CH_IDLE: begin
        out_d       = 1'b0;
        cnt_d       = '0;
        // Idle channels take a new setting at once, including one written
        // on the very edge that arms the channel.
        act_half_d  = sh_half_d;
        act_phase_d = sh_phase_d;
        if (en) state_d = CH_ARM;
      end
      CH_ARM: begin
        if (!en) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == act_phase_q) begin
          // First rising boundary: load the settings held before this edge.
          state_d     = CH_RUN;
          out_d       = 1'b1;
          cnt_d       = '0;
          act_half_d  = sh_half_q;
          act_phase_d = sh_phase_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      CH_RUN: begin
        if (!en && !out_q) begin
          // Low phase: stopping here cannot shorten a high pulse.
          state_d = CH_IDLE;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          if (at_last) begin
            out_d = ~out_q;
            cnt_d = '0;
            if (!out_q) begin
              // Rising boundary: a write landing on this same edge is still
              // only in the shadow and waits for the next boundary.
              act_half_d  = sh_half_q;
              act_phase_d = sh_phase_q;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          if (!en) state_d = CH_STOP;
        end
      end
      CH_STOP: begin
        // Finish the high phase, then spend one low cycle here before idle.
        // en is deliberately ignored until the channel is back in IDLE.
        if (out_q) begin
          if (at_last) begin
            out_d = 1'b0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end else begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CH_IDLE;
        out_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset returns to idle with H=1, P=0 in both copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CH_IDLE;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      sh_half_q   <= DIV_W'(1);
      sh_phase_q  <= '0;
      act_half_q  <= DIV_W'(1);
      act_phase_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      sh_half_q   <= sh_half_d;
      sh_phase_q  <= sh_phase_d;
      act_half_q  <= act_half_d;
      act_phase_q <= act_phase_d;
    end
  end

  assign clk_out = out_q;
  assign running = (state_q == CH_RUN) || (state_q == CH_STOP);
  assign state_o = state_q;

endmodule

// File: rtl/multi_phase_clk_gen.sv
// Multi-phase clock generator: NUM_CH independent divided clocks, each with
// its own half-period and start delay, programmed via one config port.
module multi_phase_clk_gen
  import clkgen_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DIV_W  = DEF_DIV_W,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_half,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   running,
  output logic [2*NUM_CH-1:0] dbg_state
);

  // Config handshake: a write is taken on a rising clk edge where
  // cfg_valid && cfg_ready. cfg_ready is high whenever reset is released, so
  // a write never stalls; a write naming a channel that does not exist is
  // dropped silently.
  assign cfg_ready = rst_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_valid && cfg_ready && (int'(cfg_ch) == i);

    clkgen_channel #(
      .DIV_W (DIV_W)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[i]),
      .wr_en    (wr_en),
      .wr_half  (cfg_half),
      .wr_phase (cfg_phase),
      .clk_out  (clk_out[i]),
      .running  (running[i]),
      .state_o  (dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_multi_phase_clk_gen.sv
// Bench for multi_phase_clk_gen (3 channels so an out-of-range cfg_ch exists).
// Each clk_out transition is an output event {cycle, channel, level}.
module tb_multi_phase_clk_gen;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int EW  = 21;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] ch_en = '0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [DW-1:0]  cfg_half = '0;
  logic [DW-1:0]  cfg_phase = '0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] running;
  logic [2*NCH-1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int k;
  logic mon_on = 1'b0;
  logic [NCH-1:0] prev_out = '0;
  logic [EW-1:0] exp_q[$];

  multi_phase_clk_gen #(
    .NUM_CH (NCH),
    .DIV_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_phase (cfg_phase),
    .clk_out   (clk_out),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // clock / cycle count: after posedge number n, cyc == n
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: pop and compare on every clk_out transition
  always @(negedge clk) begin
    logic [EW-1:0] got, ex;
    for (int i = 0; i < NCH; i++) begin
      if (mon_on && (clk_out[i] !== prev_out[i])) begin
        got = {cyc[15:0], 4'(i), clk_out[i]};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL edge_unexpected got cyc=%0d ch=%0d lvl=%0d required no edge",
                   got[20:5], got[4:1], got[0]);
        end else begin
          ex = exp_q.pop_front();
          if (got !== ex) begin
            bad++;
            $display("FAIL edge got cyc=%0d ch=%0d lvl=%0d required cyc=%0d ch=%0d lvl=%0d",
                     got[20:5], got[4:1], got[0], ex[20:5], ex[4:1], ex[0]);
          end
        end
      end
    end
    prev_out = clk_out;
  end

  function automatic void push(input int c, input int ch, input int lvl);
    exp_q.push_back({16'(c), 4'(ch), 1'(lvl)});
  endfunction

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // driver: called at a negedge, write is taken at the next posedge
  task automatic cfg_write(input int ch, input int h, input int p);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_half  = DW'(h);
    cfg_phase = DW'(p);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_running", int'(running), 0);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    mon_on = 1'b1;

    // A: H=3 P=0 -> rise k+1, fall k+4, rise k+7
    cfg_write(0, 3, 0);
    k = cyc + 1; ch_en[0] = 1'b1;
    push(k+1, 0, 1); push(k+4, 0, 0); push(k+7, 0, 1); push(k+10, 0, 0);
    wait_cyc(k+5);
    check("a_running", int'(running[0]), 1);
    check("a_state_run", int'(dbg_state[1:0]), 2);
    wait_cyc(k+10); ch_en[0] = 1'b0;
    wait_cyc(k+11);
    check("a_stopped", int'(running[0]), 0);

    // B: ch0 H=2 P=0, ch1 H=2 P=1, ch1 lags by one cycle
    cfg_write(0, 2, 0);
    cfg_write(1, 2, 1);
    k = cyc + 1; ch_en[1:0] = 2'b11;
    push(k+1, 0, 1); push(k+2, 1, 1); push(k+3, 0, 0); push(k+4, 1, 0);
    push(k+5, 0, 1); push(k+6, 1, 1); push(k+7, 0, 0); push(k+8, 1, 0);
    wait_cyc(k+8); ch_en[1:0] = 2'b00;
    wait_cyc(k+9);
    check("b_idle", int'(running[1:0]), 0);

    // C: H=4, ch_en low one cycle after rise -> full high, STOP, re-arm
    cfg_write(0, 4, 0);
    k = cyc + 1; ch_en[0] = 1'b1;
    push(k+1, 0, 1); push(k+5, 0, 0); push(k+8, 0, 1); push(k+12, 0, 0);
    wait_cyc(k+1); ch_en[0] = 1'b0;
    wait_cyc(k+3);
    check("c_state_stop", int'(dbg_state[1:0]), 3);
    ch_en[0] = 1'b1;
    wait_cyc(k+5);
    check("c_running_stop", int'(running[0]), 1);
    wait_cyc(k+6);
    check("c_running_off", int'(running[0]), 0);
    wait_cyc(k+7);
    check("c_rearm", int'(dbg_state[1:0]), 1);
    wait_cyc(k+12); ch_en[0] = 1'b0;
    wait_cyc(k+13);
    check("c_idle", int'(dbg_state[1:0]), 0);

    // D: H=2 then H=5 mid-high; H=1 written on a rising boundary
    cfg_write(0, 2, 0);
    k = cyc + 1; ch_en[0] = 1'b1;
    push(k+1, 0, 1); push(k+3, 0, 0); push(k+5, 0, 1); push(k+10, 0, 0);
    push(k+15, 0, 1); push(k+20, 0, 0); push(k+25, 0, 1); push(k+26, 0, 0);
    wait_cyc(k+1); cfg_write(0, 5, 0);
    wait_cyc(k+14); cfg_write(0, 1, 0);
    wait_cyc(k+26); ch_en[0] = 1'b0;
    wait_cyc(k+27);
    check("d_idle", int'(running[0]), 0);

    // E: ch2 H=0 -> period 2; write to cfg_ch=3 must change nothing
    cfg_write(2, 0, 0);
    cfg_write(3, 7, 5);
    k = cyc + 1; ch_en = 3'b111;
    push(k+1, 0, 1); push(k+1, 2, 1);
    push(k+2, 0, 0); push(k+2, 1, 1); push(k+2, 2, 0);
    push(k+3, 0, 1); push(k+3, 2, 1);
    push(k+4, 0, 0); push(k+4, 1, 0); push(k+4, 2, 0);
    wait_cyc(k+4); ch_en = 3'b000;
    wait_cyc(k+5);
    check("e_idle", int'(running), 0);

    // F: async reset mid-RUN, then H must be back to 1
    cfg_write(0, 3, 0);
    k = cyc + 1; ch_en[0] = 1'b1;
    push(k+1, 0, 1); push(k+4, 0, 0); push(k+7, 0, 1); push(k+9, 0, 0);
    wait_cyc(k+8);
    #2 rst_n = 1'b0; ch_en = '0;
    #1;
    check("f_rst_clk_out", int'(clk_out), 0);
    check("f_rst_running", int'(running), 0);
    check("f_rst_state", int'(dbg_state), 0);
    check("f_rst_ready", int'(cfg_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("f_rel_ready", int'(cfg_ready), 1);
    @(negedge clk);
    k = cyc + 1; ch_en[0] = 1'b1;
    push(k+1, 0, 1); push(k+2, 0, 0); push(k+3, 0, 1); push(k+4, 0, 0);
    wait_cyc(k+4); ch_en[0] = 1'b0;
    wait_cyc(k+6);
    check("f_idle", int'(dbg_state[1:0]), 0);

    // final report: expected edges that never arrived are failures
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      logic [EW-1:0] ex;
      ex = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL edge_missing got none required cyc=%0d ch=%0d lvl=%0d",
               ex[20:5], ex[4:1], ex[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
